scan_sig_checker: RTL and testbench
===================================

// Module: scan_sig_checker
// PURPOSE
//  Consumes the serial scan-out stream of a DFF/DFFSR scan chain, one bit per cycle.
//  Compacts the stream into a MISR signature and compares it with a golden value at end of frame.
//  Sits at the far end of the chain, opposite the pattern/shift-in driver.
//  Gives the test bench a pass/fail verdict for each scan unload.
// PARAMETERS
//  SIG_W      16       signature width, >=2
//  POLY       16'h1021 MISR feedback polynomial, x^SIG_W term implicit
//  SEED       16'h0000 signature value loaded at frame start
//  CHAIN_LEN  64       bits per frame, >=1
//  CNT_W      7        bit-counter width, must satisfy 2^CNT_W > CHAIN_LEN
// PORTS
//  C          in   1      clock; all state updates on posedge C
//  R          in   1      synchronous reset, active high
//  start      in   1      begin a frame; golden sampled on the same edge
//  golden     in   SIG_W  expected signature
//  sin_valid  in   1      serial bit valid
//  sin_data   in   1      serial scan-out bit
//  sin_ready  out  1      checker can accept a bit (registered)
//  busy       out  1      frame in progress (SHIFT or CHECK)
//  done       out  1      verdict valid; held until next start or R
//  pass       out  1      signature==golden; meaningful only while done=1
//  signature  out  SIG_W  current MISR contents
// BEHAVIOUR
//  Reset (R=1 at posedge C): state=IDLE, signature=SEED, cnt=0, sin_ready=busy=done=pass=0.
//    Reset mid-frame discards the frame; no verdict is produced.
//  FSM states: IDLE, SHIFT, CHECK, DONE.
//  IDLE:  start=1 -> SHIFT; signature<=SEED; cnt<=0; golden_q<=golden; sin_ready<=1.
//  SHIFT: a beat is accepted when sin_valid & sin_ready.
//    On a beat: sig <= {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ {0,...,sin_data}.
//    On a beat: cnt <= cnt+1.
//    sin_valid=0 is a stall: signature and cnt hold, with no timeout.
//    Beat with cnt==CHAIN_LEN-1 -> CHECK; sin_ready<=0 on the same edge.
//    No further bits are taken in that frame.
//    start is ignored in SHIFT and in CHECK.
//  CHECK: exactly one cycle; pass <= (signature==golden_q); done <= 1 -> DONE.
//    done/pass are visible 2 edges after the last accepted beat.
//  DONE: done, pass and signature hold.
//    start=1 -> SHIFT with the same actions as from IDLE; done<=0 and pass<=0 on that edge.
//  busy = (state==SHIFT || state==CHECK), decoded from the state register.
//  CHAIN_LEN=1: the first beat moves SHIFT -> CHECK.
//  R and start in the same cycle: R wins.
//  golden changing after start has no effect (latched copy is used).
// STRUCTURE
//  Package scan_pkg holds:
//    state enum typedef (IDLE/SHIFT/CHECK/DONE)
//    defaults POLY_DEF=16'h1021 and SEED_DEF=16'h0000
//  Sub-module misr_reg (C, R, en, seed_ld, din, q) holds the signature register and feedback logic.
//  Top-level block holds the FSM, bit counter, golden latch and handshake.
// TESTING
//  1 All-zero frame: start, golden=0, 64 beats of 0 -> done=1, pass=1, signature=16'h0000.
//  2 Single one, last bit: 63 zeros then 1, golden=16'h0001 -> pass=1, signature=16'h0001.
//  3 One at bit 62: ...,1,0 pattern -> signature=16'h0002.
//    Same stream with golden=16'h0001 -> pass=0.
//  4 Stalls: case-2 stream with sin_valid low for 3 cycles every 8 beats.
//    Expected: identical signature; done 2 edges after the 64th beat; sin_ready=0 from then on.
//  5 Reset mid-frame: R after 10 beats -> next cycle busy=0, sin_ready=0, done=0, signature=SEED.
//    A new start then runs a clean case-1 frame -> pass=1.
//  6 Start is ignored while busy: start pulsed during SHIFT and CHECK -> cnt not cleared, verdict unchanged.
//    Start in DONE -> done drops the next cycle and a new frame begins.

Source files
------------

// File: rtl/scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : scan_pkg
//  Description : Shared types and default constants for the scan-chain
//                signature checker (FSM state encoding, MISR defaults).
//  Revision    : 1.0  initial release
// ============================================================================
package scan_pkg;

    // Checker FSM states; 2-bit encoding covers all four states exactly.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Default MISR feedback polynomial (x^16 term implicit) and seed.
    localparam logic [15:0] POLY_DEF = 16'h1021;
    localparam logic [15:0] SEED_DEF = 16'h0000;

endpackage : scan_pkg
`default_nettype wire

// File: rtl/misr_reg.sv
`default_nettype none
// ============================================================================
//  Module      : misr_reg
//  Description : Single-input signature register. Each enabled cycle shifts
//                the register left, folds the outgoing MSB back through the
//                feedback polynomial and XORs the serial input into bit 0.
//  Ports       : C        in   clock
//                R        in   synchronous reset, active high (loads SEED)
//                en       in   compact din this cycle
//                seed_ld  in   reload SEED (frame start), wins over en
//                din      in   serial input bit
//                q        out  current signature
//  Revision    : 1.0  initial release
// ============================================================================
module misr_reg
    import scan_pkg::*;
#(
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = POLY_DEF,
    parameter logic [SIG_W-1:0] SEED  = SEED_DEF
) (
    input  logic             C,
    input  logic             R,
    input  logic             en,
    input  logic             seed_ld,
    input  logic             din,
    output logic [SIG_W-1:0] q
);

    logic [SIG_W-1:0] w_fb;
    logic [SIG_W-1:0] w_next;

    // Feedback only applies when a one is shifted out of the MSB.
    assign w_fb   = q[SIG_W-1] ? POLY : '0;
    assign w_next = {q[SIG_W-2:0], 1'b0} ^ w_fb ^ {{(SIG_W-1){1'b0}}, din};

    always_ff @(posedge C) begin
        if (R) begin
            q <= SEED;
        end else if (seed_ld) begin
            q <= SEED;
        end else if (en) begin
            q <= w_next;
        end
    end

endmodule : misr_reg
`default_nettype wire

// File: rtl/scan_sig_checker.sv
`default_nettype none
// ============================================================================
//  Module      : scan_sig_checker
//  Description : Compacts a serial scan-out stream into a MISR signature and
//                compares it against a golden value latched at frame start.
//  Ports       : C          in   clock
//                R          in   synchronous reset, active high
//                start      in   begin a frame (golden sampled on same edge)
//                golden     in   expected signature
//                sin_valid  in   serial bit valid
//                sin_data   in   serial scan-out bit
//                sin_ready  out  checker accepts a bit (registered)
//                busy       out  frame in progress (SHIFT or CHECK)
//                done       out  verdict valid, held until next start or R
//                pass       out  signature matched golden (valid with done)
//                signature  out  current MISR contents
//  Revision    : 1.0  initial release
// ============================================================================
module scan_sig_checker
    import scan_pkg::*;
#(
    parameter int               SIG_W     = 16,
    parameter logic [SIG_W-1:0] POLY      = POLY_DEF,
    parameter logic [SIG_W-1:0] SEED      = SEED_DEF,
    parameter int               CHAIN_LEN = 64,
    parameter int               CNT_W     = 7
) (
    input  logic             C,
    input  logic             R,
    input  logic             start,
    input  logic [SIG_W-1:0] golden,
    input  logic             sin_valid,
    input  logic             sin_data,
    output logic             sin_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(CHAIN_LEN - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [SIG_W-1:0] r_golden;
    logic             w_beat;
    logic             w_load;

    // sin_ready is only ever set while in SHIFT, so the state term is
    // redundant but keeps the beat strictly confined to the shift phase.
    assign w_beat = (r_state == ST_SHIFT) && sin_valid && sin_ready;

    // A frame may be (re)started from IDLE or DONE only.
    assign w_load = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    assign busy = (r_state == ST_SHIFT) || (r_state == ST_CHECK);

    misr_reg #(
        .SIG_W (SIG_W),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .C       (C),
        .R       (R),
        .en      (w_beat),
        .seed_ld (w_load),
        .din     (sin_data),
        .q       (signature)
    );

    always_ff @(posedge C) begin
        if (R) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_golden  <= '0;
            sin_ready <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state   <= ST_SHIFT;
                        r_cnt     <= '0;
                        r_golden  <= golden;
                        sin_ready <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (w_beat) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == c_last) begin
                            r_state   <= ST_CHECK;
                            sin_ready <= 1'b0;
                        end
                    end
                end
                ST_CHECK: begin
                    // Signature already includes the final beat here.
                    pass    <= (signature == r_golden);
                    done    <= 1'b1;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    if (start) begin
                        r_state   <= ST_SHIFT;
                        r_cnt     <= '0;
                        r_golden  <= golden;
                        sin_ready <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : scan_sig_checker
`default_nettype wire

// File: tb/tb_scan_sig_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scan_sig_checker
//  Description : Self-checking bench for scan_sig_checker. Expected verdicts
//                are queued when a frame is issued; a monitor pops and
//                compares them whenever done rises.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_scan_sig_checker;

    typedef struct {
        logic [15:0] sig;
        logic        pass;
    } exp_t;

    logic        C;
    logic        R;
    logic        start;
    logic [15:0] golden;
    logic        sin_valid;
    logic        sin_data;
    logic        sin_ready;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] signature;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    logic prev_done = 1'b0;

    scan_sig_checker dut (
        .C         (C),
        .R         (R),
        .start     (start),
        .golden    (golden),
        .sin_valid (sin_valid),
        .sin_data  (sin_data),
        .sin_ready (sin_ready),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .signature (signature)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Signature as polynomial long division over GF(2): each bit is appended
    // to the running remainder, reduced modulo x^16 + x^12 + x^5 + 1.
    function automatic logic [15:0] model_sig(input logic [63:0] v);
        int s = 0;
        for (int i = 0; i < 64; i++) begin
            s = s << 1;
            if ((s & 32'h10000) != 0) s = s ^ 32'h11021;
            s = s ^ int'(v[i]);
        end
        return s[15:0];
    endfunction

    // Monitor: every rising edge of done must match the oldest expectation.
    always @(negedge C) begin
        if (done && !prev_done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_signature", 32'(signature), 32'(e.sig));
                chk("sb_pass", 32'(pass), 32'(e.pass));
            end
        end
        prev_done = done;
    end

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    task automatic do_start(input logic [15:0] g);
        start  = 1'b1;
        golden = g;
        tick();
        start  = 1'b0;
        golden = $urandom;  // later changes must not matter
    endtask

    // mode 0: no stalls, 1: 3-cycle stall after every 8 beats, 2: random.
    // mid_start pulses start during a stall in SHIFT and during CHECK.
    task automatic send_frame(input logic [63:0] v, input logic [15:0] g,
                              input int mode, input bit mid_start);
        exp_t e;
        e.sig  = model_sig(v);
        e.pass = (e.sig == g);
        exp_q.push_back(e);
        do_start(g);
        chk("ready_at_start", 32'(sin_ready), 32'd1);
        chk("busy_at_start", 32'(busy), 32'd1);
        for (int i = 0; i < 64; i++) begin
            sin_valid = 1'b1;
            sin_data  = v[i];
            tick();
            sin_valid = 1'b0;
            if (i == 63) break;
            if (mode == 1 && (i % 8) == 7) repeat (3) tick();
            if (mode == 2) begin
                for (int k = 0; k < 4 && $urandom_range(0, 2) == 0; k++) tick();
            end
            if (mid_start && i == 20) begin
                start = 1'b1;
                tick();
                start = 1'b0;
            end
        end
        // Now in CHECK: no verdict yet, shifting closed.
        chk("done_after_last_beat", 32'(done), 32'd0);
        chk("ready_after_last_beat", 32'(sin_ready), 32'd0);
        if (mid_start) start = 1'b1;
        tick();
        start = 1'b0;
        chk("done_two_edges", 32'(done), 32'd1);
        chk("busy_in_done", 32'(busy), 32'd0);
        chk("ready_in_done", 32'(sin_ready), 32'd0);
    endtask

    logic [63:0] v;
    logic [15:0] held;

    initial begin
        R = 1'b1; start = 1'b0; golden = '0; sin_valid = 1'b0; sin_data = 1'b0;
        tick(); tick();
        R = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(sin_ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_sig", 32'(signature), 32'd0);

        // Directed frames.
        send_frame(64'd0, 16'h0000, 0, 0);
        chk("t1_sig", 32'(signature), 32'h0000);
        send_frame(64'h8000_0000_0000_0000, 16'h0001, 0, 0);
        chk("t2_sig", 32'(signature), 32'h0001);
        send_frame(64'h4000_0000_0000_0000, 16'h0002, 0, 0);
        chk("t3_sig", 32'(signature), 32'h0002);
        send_frame(64'h4000_0000_0000_0000, 16'h0001, 0, 0);
        chk("t3_pass_low", 32'(pass), 32'd0);

        // Stalls with the case-2 stream; extra valid beats in DONE are ignored.
        send_frame(64'h8000_0000_0000_0000, 16'h0001, 1, 0);
        chk("t4_sig", 32'(signature), 32'h0001);
        sin_valid = 1'b1; sin_data = 1'b1;
        repeat (3) tick();
        sin_valid = 1'b0;
        chk("t4_sig_hold", 32'(signature), 32'h0001);
        chk("t4_done_hold", 32'(done), 32'd1);
        chk("t4_ready_hold", 32'(sin_ready), 32'd0);

        // Start in DONE: done drops next cycle, new frame begins.
        start = 1'b1; golden = 16'h0;
        tick();
        start = 1'b0;
        chk("t6_done_drop", 32'(done), 32'd0);
        chk("t6_busy", 32'(busy), 32'd1);
        chk("t6_sig_seed", 32'(signature), 32'h0000);

        // Reset mid-frame (10 one-beats first so the signature is non-seed).
        for (int i = 0; i < 10; i++) begin
            sin_valid = 1'b1; sin_data = 1'b1;
            tick();
        end
        sin_valid = 1'b0;
        chk("t5_sig_moved", 32'(signature != 16'h0), 32'd1);
        R = 1'b1; start = 1'b1;
        tick();
        R = 1'b0; start = 1'b0;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_ready", 32'(sin_ready), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_sig", 32'(signature), 32'h0000);
        send_frame(64'd0, 16'h0000, 0, 0);
        chk("t5_clean_pass", 32'(pass), 32'd1);

        // Start pulsed during SHIFT and CHECK must be ignored.
        v = {$urandom, $urandom};
        send_frame(v, model_sig(v), 0, 1);
        held = signature;
        tick();
        chk("t6_verdict_hold", 32'(pass), 32'd1);
        chk("t6_sig_hold", 32'(signature), 32'(held));

        // Randomized frames with random stalls and mixed goldens.
        for (int n = 0; n < 12; n++) begin
            v = {$urandom, $urandom};
            send_frame(v, ($urandom_range(0, 1) == 1) ? model_sig(v) : 16'($urandom),
                       2, ($urandom_range(0, 3) == 0));
        end

        // Let the monitor drain, with a bound.
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_scan_sig_checker
`default_nettype wire
